// File: rtl/alu_pkg.sv
// Shared types for the ALU operand issue stage: operand widths, the queued
// request record and the issue FSM state encoding.
package alu_pkg;

    localparam int N     = 8;
    localparam int M     = 16;
    localparam int SEL_W = 3;

    typedef struct packed {
        logic [N-1:0]     a;
        logic [N-1:0]     b;
        logic [SEL_W-1:0] sel;
    } alu_req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } issue_state_t;

endpackage

// File: rtl/alu_req_fifo.sv
// Request FIFO of alu_req_t entries. Pointers carry one extra wrap bit so a
// full queue and an empty queue can be told apart without a separate counter.
module alu_req_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  alu_req_t wr_data,
    input  logic     pop,
    output alu_req_t rd_data,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    alu_req_t        mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Operand issue stage in front of the combinational ALU: queues requests,
// issues one at a time and holds the result for downstream.
// Optional completed-result counter on op_cnt: define ALU_ISSUE_CNT_EN.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic [SEL_W-1:0] in_sel,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [M-1:0]     alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [M-1:0]     res_data,
    output logic [SEL_W-1:0] res_sel,
    output logic [15:0]      op_cnt
);

    issue_state_t state, state_nxt;
    alu_req_t     wr_req;
    alu_req_t     head;
    logic         fifo_full;
    logic         fifo_empty;
    logic         pop;

    assign wr_req   = {in_a, in_b, in_sel};
    assign in_ready = !fifo_full;

    alu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (in_valid),
        .wr_data (wr_req),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Empty is the pre-push view, so a request needs one edge in the queue
    // before it can be issued.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (res_ready) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
        end else if (pop) begin
            alu_a   <= head.a;
            alu_b   <= head.b;
            alu_sel <= head.sel;
        end
    end

    // res_data/res_sel keep their last value after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_sel   <= '0;
        end else if (state == ISSUE) begin
            res_valid <= 1'b1;
            res_data  <= alu_out;
            res_sel   <= alu_sel;
        end else if (state == WAIT && res_ready) begin
            res_valid <= 1'b0;
        end
    end

`ifdef ALU_ISSUE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      op_cnt <= '0;
        else if (res_valid && res_ready) op_cnt <= op_cnt + 16'd1;
    end
`else
    assign op_cnt = '0;
`endif

endmodule
